// File: rtl/conv_pkg.sv
// Shared sizing constants and state encoding for the conv_96_65_16_16 host.
package conv_pkg;

  localparam int N         = 96;              // x samples per run
  localparam int M         = 65;              // filter taps
  localparam int T         = 16;              // sample width
  localparam int L         = N - M + 1;       // results per run
  localparam int LOGSIZE_N = $clog2(N);
  localparam int LOGSIZE_L = $clog2(L);
  localparam int CSUM_W    = T + LOGSIZE_L + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2
  } host_state_t;

endpackage

// File: rtl/stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to insert handshake stalls.
// Only compiled when CONV_HOST_THROTTLE_EN is defined.
`ifdef CONV_HOST_THROTTLE_EN
module stall_lfsr (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [15:0] o_lfsr,
  output logic [15:0] o_lfsr_next
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_lfsr_next = {r_lfsr[14:0], w_fb};
  assign o_lfsr      = r_lfsr;

  // Step every cycle; reset reloads the seed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= o_lfsr_next;
    end
  end

endmodule
`endif

// File: rtl/conv_stream_host.sv
// Host-side initiator for conv_96_65_16_16: streams a preloaded x vector out,
// collects L results into a readable buffer, tracks checksum and maximum.
// Optional stall insertion: define CONV_HOST_THROTTLE_EN.
module conv_stream_host
  import conv_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [LOGSIZE_N-1:0] i_wr_addr,
  input  logic [T-1:0]         i_wr_data,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [T-1:0]         o_x_data,
  output logic                 o_x_valid,
  input  logic                 i_x_ready,
  input  logic [T-1:0]         i_y_data,
  input  logic                 i_y_valid,
  output logic                 o_y_ready,
  input  logic [LOGSIZE_L-1:0] i_rd_addr,
  output logic [T-1:0]         o_rd_data,
  output logic [CSUM_W-1:0]    o_checksum,
  output logic [T-1:0]         o_y_max
);

  host_state_t          r_state;
  logic [LOGSIZE_N-1:0] r_send_cnt;
  logic [LOGSIZE_L-1:0] r_recv_cnt;
  logic                 r_x_valid;
  logic                 r_y_ready;
  logic                 r_done;
  logic [CSUM_W-1:0]    r_checksum;
  logic [T-1:0]         r_y_max;
  logic [T-1:0]         r_rd_data;
  logic [T-1:0]         r_xbuf [N];
  logic [T-1:0]         r_ybuf [L];

  logic                 w_x_fire;
  logic                 w_y_fire;
  logic                 w_x_gate;   // x_valid may rise in the coming cycle
  logic                 w_y_gate;   // y_ready may be high in the coming cycle

`ifdef CONV_HOST_THROTTLE_EN
  logic [15:0] w_lfsr;
  logic [15:0] w_lfsr_next;

  stall_lfsr u_stall_lfsr (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .o_lfsr      (w_lfsr),
    .o_lfsr_next (w_lfsr_next)
  );

  // Registered handshake flags are computed from the LFSR value of the cycle
  // they will be visible in, so x_valid rises only when lfsr[0] = 0 and
  // y_ready tracks ~lfsr[1] cycle by cycle.
  assign w_x_gate = ~w_lfsr_next[0];
  assign w_y_gate = ~w_lfsr_next[1];
`else
  assign w_x_gate = 1'b1;
  assign w_y_gate = 1'b1;
`endif

  assign w_x_fire   = r_x_valid & i_x_ready;
  assign w_y_fire   = r_y_ready & i_y_valid;
  assign o_x_data   = r_xbuf[r_send_cnt];
  assign o_x_valid  = r_x_valid;
  assign o_y_ready  = r_y_ready;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_checksum = r_checksum;
  assign o_y_max    = r_y_max;
  assign o_rd_data  = r_rd_data;

  // Run sequencer: IDLE -> SEND (N x transfers) -> RECV (L y transfers).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_send_cnt <= '0;
      r_recv_cnt <= '0;
      r_x_valid  <= 1'b0;
      r_y_ready  <= 1'b0;
      r_done     <= 1'b0;
      r_checksum <= '0;
      r_y_max    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_SEND;
            r_send_cnt <= '0;
            r_recv_cnt <= '0;
            r_checksum <= '0;
            r_y_max    <= '0;
            r_done     <= 1'b0;
            r_x_valid  <= w_x_gate;
          end
        end
        ST_SEND: begin
          if (w_x_fire) begin
            if (r_send_cnt == LOGSIZE_N'(N - 1)) begin
              r_state   <= ST_RECV;
              r_x_valid <= 1'b0;
              r_y_ready <= w_y_gate;
            end else begin
              r_send_cnt <= r_send_cnt + 1'b1;
              r_x_valid  <= w_x_gate;
            end
          end else if (!r_x_valid) begin
            // A raised x_valid is held until its handshake completes.
            r_x_valid <= w_x_gate;
          end
        end
        ST_RECV: begin
          if (w_y_fire) begin
            r_checksum <= r_checksum + CSUM_W'(i_y_data);
            if ($signed(i_y_data) > $signed(r_y_max)) begin
              r_y_max <= i_y_data;
            end
            if (r_recv_cnt == LOGSIZE_L'(L - 1)) begin
              r_state   <= ST_IDLE;
              r_y_ready <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_recv_cnt <= r_recv_cnt + 1'b1;
              r_y_ready  <= w_y_gate;
            end
          end else begin
            r_y_ready <= w_y_gate;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_x_valid <= 1'b0;
          r_y_ready <= 1'b0;
        end
      endcase
    end
  end

  // Sample buffer: host writes land only while idle and in range.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (r_state == ST_IDLE) && (i_wr_addr < LOGSIZE_N'(N))) begin
      r_xbuf[i_wr_addr] <= i_wr_data;
    end
  end

  // Result buffer: capture each accepted y at the current receive index.
  always_ff @(posedge i_clk) begin
    if (w_y_fire) begin
      r_ybuf[r_recv_cnt] <= i_y_data;
    end
  end

  // Registered result read port, legal in any state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_ybuf[i_rd_addr];
    end
  end

endmodule
